// File: rtl/sha256_corner_bist.sv
// Built-in self-test sequencer for sha256_core: drives corner-case blocks
// through the core twice each, checks completion, validity and determinism,
// and folds every first-run digest into a 32-bit signature.
module sha256_corner_bist #(
  parameter int unsigned NUM_PATTERNS   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 128,
  parameter bit          CHECK_SIG      = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              mode_cfg,
  input  logic [31:0]                       exp_sig,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              aborted,
  output logic [$clog2(NUM_PATTERNS+1)-1:0] fail_count,
  output logic [31:0]                       signature,
  output logic                              core_init,
  output logic                              core_next,
  output logic                              core_mode,
  output logic [511:0]                      core_block,
  input  logic                              core_ready,
  input  logic [255:0]                      core_digest,
  input  logic                              core_digest_valid
);

  localparam int unsigned CW = $clog2(NUM_PATTERNS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] NP_EXT = (CW + 1)'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  fail_q, fail_d;
  logic           run_q, run_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [31:0]    sig_q, sig_d;
  logic           aborted_q, aborted_d;
  logic           pfail_q, pfail_d;
  logic [255:0]   cap_q, cap_d;
  logic           mode_q, mode_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;

  logic           init_c;
  logic [TW-1:0]  timer_inc;
  logic           timeout;
  logic [31:0]    fold;
  logic [CW:0]    fail_sum;
  logic [31:0]    pat_k;
  logic [8:0]     pat_sh;

  // Corner-case pattern selected by the current pattern index
  always_comb begin
    pat_k  = 32'(idx_q);
    pat_sh = 9'(pat_k - 32'd4);
    if (pat_k == 32'd0)      core_block = '0;
    else if (pat_k == 32'd1) core_block = '1;
    else if (pat_k == 32'd2) core_block = {128{4'hA}};
    else if (pat_k == 32'd3) core_block = {128{4'h5}};
    else                     core_block = 512'd1 << pat_sh;
  end

  // XOR of the eight 32-bit digest words
  always_comb begin
    fold = '0;
    for (int w = 0; w < 8; w++) fold = fold ^ core_digest[32*w +: 32];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    run_d     = run_q;
    timer_d   = timer_q;
    sig_d     = sig_q;
    aborted_d = aborted_q;
    pfail_d   = pfail_q;
    cap_d     = cap_q;
    mode_d    = mode_q;
    init_c    = 1'b0;
    timer_inc = timer_q + TW'(1);
    timeout   = (timer_inc == TW'(TIMEOUT_CYCLES));
    // completed failures plus every unfinished pattern, current one included
    fail_sum  = {1'b0, fail_q} + NP_EXT - {1'b0, idx_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d    = mode_cfg;
          idx_d     = '0;
          run_d     = 1'b0;
          sig_d     = '0;
          fail_d    = '0;
          aborted_d = 1'b0;
          pfail_d   = 1'b0;
          timer_d   = '0;
          state_d   = S_START;
        end
      end
      S_START, S_WAIT: begin
        timer_d = timer_inc;
        if (timeout) begin
          aborted_d = 1'b1;
          fail_d    = (fail_sum > NP_EXT) ? CW'(NUM_PATTERNS) : fail_sum[CW-1:0];
          state_d   = S_DONE;
        end else if (state_q == S_START) begin
          if (core_ready) begin
            init_c  = 1'b1;
            timer_d = '0;
            state_d = S_WAIT;
          end
        end else if (timer_q != '0 && core_ready) begin
          // timer_q is zero only in the first WAIT cycle, where ready is stale
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        timer_d = '0;
        if (!run_q) begin
          cap_d   = core_digest;
          pfail_d = pfail_q | ~core_digest_valid;
          sig_d   = {sig_q[30:0], sig_q[31]} ^ fold;
          run_d   = 1'b1;
          state_d = S_START;
        end else begin
          if ((pfail_q || !core_digest_valid || core_digest != cap_q) &&
              fail_q != CW'(NUM_PATTERNS)) begin
            fail_d = fail_q + CW'(1);
          end
          pfail_d = 1'b0;
          run_d   = 1'b0;
          idx_d   = idx_q + CW'(1);
          state_d = (idx_q == CW'(NUM_PATTERNS - 1)) ? S_DONE : S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && !aborted_d && (fail_d == '0) &&
             (!CHECK_SIG || sig_d == exp_sig);
  end

  // State and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      fail_q    <= '0;
      run_q     <= 1'b0;
      timer_q   <= '0;
      sig_q     <= '0;
      aborted_q <= 1'b0;
      pfail_q   <= 1'b0;
      cap_q     <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fail_q    <= fail_d;
      run_q     <= run_d;
      timer_q   <= timer_d;
      sig_q     <= sig_d;
      aborted_q <= aborted_d;
      pfail_q   <= pfail_d;
      cap_q     <= cap_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign aborted    = aborted_q;
  assign fail_count = fail_q;
  assign signature  = sig_q;
  assign core_mode  = mode_q;
  assign core_next  = 1'b0;
  assign core_init  = init_c;

endmodule

// File: tb/tb_sha256_corner_bist.sv
// Bench for sha256_corner_bist: stub core with configurable latency and
// faults, session-level reference model, per-cycle protocol monitor.
module tb_sha256_corner_bist;

  localparam int NP = 6;
  localparam int TO = 16;
  localparam int CWB = $clog2(NP + 1);

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           mode_cfg = 1'b0;
  logic [31:0]    exp_sig = '0;
  logic           busy, done, pass, aborted;
  logic [CWB-1:0] fail_count;
  logic [31:0]    signature;
  logic           core_init, core_next, core_mode;
  logic [511:0]   core_block;

  // stub core state
  logic           s_ready = 1'b1;
  logic           s_valid = 1'b1;
  logic [255:0]   s_digest = '0;
  int             s_cnt = 0;
  int             s_init_no = 0;
  bit             stub_clear = 1'b0;

  // session configuration shared by stub and model
  int  L_cfg[12];
  int  cfg_corrupt, cfg_drop, cfg_hang;
  bit  cfg_salt;
  bit  exp_mode = 1'b0;
  bit  prev_init = 1'b0;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  sha256_corner_bist #(
    .NUM_PATTERNS(NP), .TIMEOUT_CYCLES(TO), .CHECK_SIG(1'b1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_cfg(mode_cfg),
    .exp_sig(exp_sig), .busy(busy), .done(done), .pass(pass),
    .aborted(aborted), .fail_count(fail_count), .signature(signature),
    .core_init(core_init), .core_next(core_next), .core_mode(core_mode),
    .core_block(core_block), .core_ready(s_ready), .core_digest(s_digest),
    .core_digest_valid(s_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [511:0] pat(input int k);
    logic [511:0] b;
    case (k)
      0: b = '0;
      1: b = '1;
      2: b = {128{4'hA}};
      3: b = {128{4'h5}};
      default: begin
        b = '0;
        b[(k - 4) % 512] = 1'b1;
      end
    endcase
    return b;
  endfunction

  function automatic logic [31:0] fold(input logic [255:0] d);
    logic [31:0] f;
    f = '0;
    for (int w = 0; w < 8; w++) f = f ^ d[32*w +: 32];
    return f;
  endfunction

  // digest perturbation: optional per-pattern salt, optional corruption of one run
  function automatic logic [255:0] extra(input int p, input int i);
    logic [255:0] e;
    e = '0;
    if (cfg_salt) e[31:0] = 32'(32'h9E3779B9 * 32'(p + 1));
    if (i == cfg_corrupt) e = e ^ (256'd1 << 100);
    return e;
  endfunction

  // Stub core: ready low after init, high again in the L-th cycle after it
  always @(posedge clk) begin
    if (stub_clear) begin
      s_ready   <= 1'b1;
      s_cnt     <= 0;
      s_init_no <= 0;
      s_valid   <= 1'b1;
      s_digest  <= '0;
    end else if (core_init) begin
      s_init_no <= s_init_no + 1;
      s_ready   <= 1'b0;
      s_cnt     <= (s_init_no == cfg_hang) ? 0 : L_cfg[s_init_no] - 1;
      s_digest  <= core_block[255:0] ^ extra(s_init_no / 2, s_init_no);
      s_valid   <= (s_init_no != cfg_drop);
    end else begin
      if (s_cnt != 0) s_cnt <= s_cnt - 1;
      if (s_cnt == 1) s_ready <= 1'b1;
    end
  end

  // Session reference model: outcome and DONE offset from the first START cycle
  task automatic model(input int n, output int fails, output bit ab,
                       output logic [31:0] sig, output int off, output int inits);
    logic [511:0] b;
    logic [255:0] d, d0;
    bit bad;
    int i;
    fails = 0; ab = 1'b0; sig = '0; off = 0; inits = 0; d0 = '0;
    for (int p = 0; p < n && !ab; p++) begin
      bad = 1'b0;
      for (int r = 0; r < 2 && !ab; r++) begin
        i = 2 * p + r;
        inits++;
        if (i == cfg_hang) begin
          ab = 1'b1;
          fails += n - p;
          off += 1 + TO;
        end else begin
          b = pat(p);
          d = b[255:0] ^ extra(p, i);
          if (r == 0) begin
            d0 = d;
            if (i == cfg_drop) bad = 1'b1;
            sig = {sig[30:0], sig[31]} ^ fold(d);
          end else if (i == cfg_drop || d != d0) begin
            bad = 1'b1;
          end
          off += L_cfg[i] + 2;
        end
      end
      if (!ab && bad) fails++;
    end
  endtask

  task automatic set_default();
    for (int i = 0; i < 12; i++) L_cfg[i] = 8;
    cfg_salt = 1'b0; cfg_corrupt = -1; cfg_drop = -1; cfg_hang = -1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_fail_count"}, fail_count, 0);
    chk({tag, "_signature"}, signature, 0);
    chk({tag, "_core_init"}, core_init, 0);
    chk({tag, "_core_mode"}, core_mode, 0);
    chk({tag, "_block_pat0"}, core_block == '0, 1);
  endtask

  task automatic run_session(input string tag, input bit mode, input bit good, input bit glitch);
    int e_fail, e_off, e_inits, s_cyc, n;
    bit e_ab;
    logic [31:0] e_sig;
    model(NP, e_fail, e_ab, e_sig, e_off, e_inits);
    exp_sig = good ? e_sig : e_sig ^ 32'h1;
    @(negedge clk) stub_clear = 1'b1;
    @(negedge clk) stub_clear = 1'b0;
    mode_cfg = mode; exp_mode = mode; start = 1'b1; s_cyc = cyc;
    @(negedge clk) start = 1'b0;
    n = 1;
    while (!done && n < 3000) begin
      start = (glitch && n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_done_reached"}, done, 1);
    chk({tag, "_done_latency"}, 64'(cyc - s_cyc), 64'(e_off + 1));
    chk({tag, "_fail_count"}, fail_count, 64'(e_fail));
    chk({tag, "_aborted"}, aborted, e_ab);
    chk({tag, "_signature"}, signature, e_sig);
    chk({tag, "_pass"}, pass, !e_ab && e_fail == 0 && good);
    chk({tag, "_init_pulses"}, 64'(s_init_no), 64'(e_inits));
    chk({tag, "_busy_low"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_held"}, done, 1);
  endtask

  // Per-cycle protocol monitor
  always @(negedge clk) begin
    logic [511:0] b;
    chk("core_next_zero", core_next, 0);
    if (core_init) begin
      chk("init_while_ready", s_ready, 1);
      chk("init_not_back_to_back", prev_init, 0);
      b = pat(s_init_no / 2);
      chk("init_block_pattern", core_block == b, 1);
    end
    if (busy) chk("core_mode_latched", core_mode, exp_mode);
    chk("busy_done_exclusive", busy & done, 0);
    prev_init = core_init;
  end

  initial begin
    int f, off, inits, n;
    bit ab;
    logic [31:0] sg;
    logic [511:0] b;

    set_default();
    stub_clear = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    stub_clear = 1'b0;

    // hand-derived values pinning the model
    b = pat(2); chk("pin_pat2", b[31:0], 32'hAAAAAAAA);
    b = pat(5); chk("pin_pat5", b[2:0], 3'b010);
    model(NP, f, ab, sg, off, inits);
    chk("pin_plain_off", 64'(off), 120);
    chk("pin_plain_sig", sg, 32'h0);
    cfg_salt = 1'b1;
    model(3, f, ab, sg, off, inits);
    chk("pin_salt3_sig", sg, 32'hDAA66D29);
    set_default(); cfg_hang = 2;
    model(NP, f, ab, sg, off, inits);
    chk("pin_hang_fails", 64'(f), 5);
    chk("pin_hang_off", 64'(off), 37);

    set_default();                run_session("plain", 1'b0, 1'b1, 1'b0);
    set_default();                run_session("badsig", 1'b0, 1'b0, 1'b0);
    set_default(); cfg_corrupt=5; run_session("corrupt_p2r1", 1'b1, 1'b1, 1'b0);
    set_default(); cfg_hang = 2;  run_session("hang_p1", 1'b0, 1'b1, 1'b0);
    set_default(); cfg_drop = 0; cfg_salt = 1'b1;
    run_session("drop_p0r0", 1'b0, 1'b1, 1'b0);

    // asynchronous reset in the middle of a WAIT
    set_default();
    @(negedge clk) stub_clear = 1'b1;
    @(negedge clk) stub_clear = 1'b0;
    start = 1'b1; mode_cfg = 1'b1; exp_mode = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(busy && !s_ready) && n < 100) begin @(negedge clk); n++; end
    chk("rst_reached_wait", busy && !s_ready, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    run_session("after_reset", 1'b0, 1'b1, 1'b0);

    set_default(); cfg_salt = 1'b1; run_session("repeat_a", 1'b1, 1'b1, 1'b0);
    set_default(); cfg_salt = 1'b1; run_session("repeat_b", 1'b1, 1'b1, 1'b1);

    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < 12; i++) L_cfg[i] = $urandom_range(2, 12);
      cfg_salt    = 1'($urandom_range(0, 1));
      cfg_corrupt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
      cfg_drop    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
      cfg_hang    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
      run_session("random", 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
